// File: rtl/phase_timer_pkg.sv
// phase_timer_pkg: shared state type, default marker and width helper.
// Optional feature macro: PHASE_TIMER_SATURATE_EN.
package phase_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_MARKER = 32'h7fffffff;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/phase_counter.sv
// phase_counter: one per-phase cycle counter with clear and increment.
// PHASE_TIMER_SATURATE_EN: saturate at all-ones and set sticky ovf; else wrap.
module phase_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

`ifdef PHASE_TIMER_SATURATE_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (inc) begin
      // an increment attempted at all-ones is the overflow event
      if (&cnt) ovf <= 1'b1;
      else      cnt <= cnt + 1'b1;
    end
  end
`else
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)  cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
  end

  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/phase_timer.sv
// phase_timer: N-phase chained cycle profiler with marker handoff and readout.
// Optional feature macro: PHASE_TIMER_SATURATE_EN (see phase_counter).
module phase_timer
  import phase_timer_pkg::*;
#(
  parameter int          N_PHASES   = 2,
  parameter int          CNT_W      = 32,
  parameter int          DATA_W     = 32,
  parameter logic [31:0] MARKER     = DEFAULT_MARKER,
  parameter int          AUTO_START = 1
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         start,
  input  logic [N_PHASES*DATA_W-1:0]   phase_data,
  input  logic [clog2(N_PHASES):0]     rd_sel,
  output logic [N_PHASES*CNT_W-1:0]    counts,
  output logic [CNT_W-1:0]             rd_cnt,
  output logic [clog2(N_PHASES):0]     cur_phase,
  output logic                         busy,
  output logic                         done,
  output logic [N_PHASES-1:0]          ovf
);

  localparam int IW = clog2(N_PHASES) + 1;
  localparam logic [DATA_W-1:0] MK = DATA_W'(MARKER);
  localparam logic [IW-1:0] LAST = IW'(N_PHASES - 1);

  state_t              state;
  logic                mk;
  logic                run;
  logic [N_PHASES-1:0] inc;
  logic [CNT_W-1:0]    cnt_sel;

  assign run = (state == RUN) && !start;

  always_comb begin
    mk = 1'b0;
    for (int k = 0; k < N_PHASES; k++)
      if (cur_phase == IW'(k))
        mk = (phase_data[k*DATA_W +: DATA_W] == MK);
  end

  // marker edge: active counter holds, next one takes this edge
  always_comb begin
    inc = '0;
    for (int k = 0; k < N_PHASES; k++) begin
      if (cur_phase == IW'(k) && !mk)
        inc[k] = run;
      if (k > 0 && cur_phase == IW'(k - 1) && mk)
        inc[k] = run;
    end
  end

  for (genvar k = 0; k < N_PHASES; k++) begin : g_ph
    phase_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk    (clk),
      .resetn (resetn),
      .clr    (start),
      .inc    (inc[k]),
      .cnt    (counts[k*CNT_W +: CNT_W]),
      .ovf    (ovf[k])
    );
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= (AUTO_START != 0) ? RUN : IDLE;
      cur_phase <= '0;
    end else if (start) begin
      state     <= RUN;
      cur_phase <= '0;
    end else if (state == RUN && mk) begin
      cur_phase <= cur_phase + 1'b1;
      if (cur_phase == LAST) state <= DONE;
    end
  end

  always_comb begin
    cnt_sel = '0;
    for (int k = 0; k < N_PHASES; k++)
      if (rd_sel == IW'(k))
        cnt_sel = counts[k*CNT_W +: CNT_W];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rd_cnt <= '0;
    else         rd_cnt <= cnt_sel;
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_phase_timer.sv
// tb_phase_timer: two phase_timer instances against a behavioural model.
// A: N=3, CNT_W=4, DATA_W=8, manual start.  B: N=2, CNT_W=32, auto start.
module tb_phase_timer;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic        start_a, busy_a, done_a;
  logic [23:0] data_a;
  logic [2:0]  sel_a, cp_a, ovf_a;
  logic [11:0] counts_a;
  logic [3:0]  rd_a;

  logic        start_b, busy_b, done_b;
  logic [63:0] data_b, counts_b;
  logic [1:0]  sel_b, cp_b, ovf_b;
  logic [31:0] rd_b;

  localparam logic [7:0]  MK_A = 8'hff;
  localparam logic [31:0] MK_B = 32'h7fffffff;

  phase_timer #(
    .N_PHASES(3), .CNT_W(4), .DATA_W(8),
    .MARKER(32'h7fffffff), .AUTO_START(0)
  ) dut_a (
    .clk(clk), .resetn(resetn), .start(start_a),
    .phase_data(data_a), .rd_sel(sel_a),
    .counts(counts_a), .rd_cnt(rd_a),
    .cur_phase(cp_a), .busy(busy_a),
    .done(done_a), .ovf(ovf_a)
  );

  phase_timer #(
    .N_PHASES(2), .CNT_W(32), .DATA_W(32),
    .MARKER(32'h7fffffff), .AUTO_START(1)
  ) dut_b (
    .clk(clk), .resetn(resetn), .start(start_b),
    .phase_data(data_b), .rd_sel(sel_b),
    .counts(counts_b), .rd_cnt(rd_b),
    .cur_phase(cp_b), .busy(busy_b),
    .done(done_b), .ovf(ovf_b)
  );

  int ntests = 0;
  int nfail  = 0;

  // model: state 0=idle 1=run 2=done
  int     mn[2]   = '{3, 2};
  int     mw[2]   = '{4, 32};
  int     mauto[2] = '{0, 1};
  longint mc[2][4];
  bit     mo[2][4];
  int     mph[2];
  int     mst[2];
  longint mrd[2];

  task automatic chk(string tag, logic [63:0] o,
                     logic [63:0] e);
    ntests++;
    assert (o === e) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, o, e);
    end
  endtask

  task automatic mreset();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 4; k++) begin
        mc[d][k] = 0;
        mo[d][k] = 1'b0;
      end
      mph[d] = 0;
      mrd[d] = 0;
      mst[d] = mauto[d];
    end
  endtask

  task automatic bump(int d, int k);
    longint mx;
    mx = (64'd1 << mw[d]) - 1;
    if (mc[d][k] == mx) begin
`ifdef PHASE_TIMER_SATURATE_EN
      mo[d][k] = 1'b1;
`else
      mc[d][k] = 0;
`endif
    end else begin
      mc[d][k]++;
    end
  endtask

  task automatic mstep(int d, bit s, bit [3:0] m, int sel);
    mrd[d] = (sel < mn[d]) ? mc[d][sel] : 0;
    if (s) begin
      for (int k = 0; k < 4; k++) begin
        mc[d][k] = 0;
        mo[d][k] = 1'b0;
      end
      mph[d] = 0;
      mst[d] = 1;
    end else if (mst[d] == 1) begin
      if (m[mph[d]]) begin
        if (mph[d] == mn[d] - 1) mst[d] = 2;
        else bump(d, mph[d] + 1);
        mph[d]++;
      end else begin
        bump(d, mph[d]);
      end
    end
  endtask

  function automatic bit [3:0] mk_a();
    bit [3:0] m = '0;
    for (int k = 0; k < 3; k++)
      m[k] = (data_a[k*8 +: 8] == MK_A);
    return m;
  endfunction

  function automatic bit [3:0] mk_b();
    bit [3:0] m = '0;
    for (int k = 0; k < 2; k++)
      m[k] = (data_b[k*32 +: 32] == MK_B);
    return m;
  endfunction

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("A.cnt%0d", k),
          counts_a[k*4 +: 4], mc[0][k]);
      chk($sformatf("A.ovf%0d", k), ovf_a[k], mo[0][k]);
    end
    chk("A.phase", cp_a, mph[0]);
    chk("A.busy", busy_a, mst[0] == 1);
    chk("A.done", done_a, mst[0] == 2);
    chk("A.rd", rd_a, mrd[0]);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("B.cnt%0d", k),
          counts_b[k*32 +: 32], mc[1][k]);
      chk($sformatf("B.ovf%0d", k), ovf_b[k], mo[1][k]);
    end
    chk("B.phase", cp_b, mph[1]);
    chk("B.busy", busy_b, mst[1] == 1);
    chk("B.done", done_b, mst[1] == 2);
    chk("B.rd", rd_b, mrd[1]);
  endtask

  task automatic tick();
    @(posedge clk);
    mstep(0, start_a, mk_a(), int'(sel_a));
    mstep(1, start_b, mk_b(), int'(sel_b));
    #1;
    check_all();
  endtask

  int t6e[3] = '{10, 15, 0};
  logic [63:0] t4e;

  initial begin
    resetn  = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    data_a  = '0;
    data_b  = '0;
    sel_a   = '0;
    sel_b   = '0;
    #8;
    mreset();
    check_all();
    chk("R.busyA", busy_a, 1'b0);
    chk("R.busyB", busy_b, 1'b1);
    @(negedge clk);
    resetn = 1'b1;

    // idle A holds, B counts from release
    repeat (5) tick();
    chk("T5.idle_cnt", counts_a, 0);
    chk("T5.idle_busy", busy_a, 1'b0);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("T5.busy_rise", busy_a, 1'b1);
    repeat (4) tick();
    data_b[31:0] = MK_B;
    tick();
    data_b[31:0] = '0;
    chk("T1.cnt0", counts_b[31:0], 10);
    chk("T1.cnt1_start", counts_b[63:32], 1);
    repeat (14) tick();
    data_b[63:32] = MK_B;
    tick();
    data_b[63:32] = '0;
    chk("T1.cnt1", counts_b[63:32], 15);
    chk("T1.done", done_b, 1'b1);
    chk("T1.busy", busy_b, 1'b0);
    chk("T1.phase", cp_b, 2);
`ifdef PHASE_TIMER_SATURATE_EN
    t4e = 64'd15;
`else
    t4e = 64'd4;
`endif
    chk("T4.cnt0", counts_a[3:0], t4e);
`ifdef PHASE_TIMER_SATURATE_EN
    chk("T4.ovf0", ovf_a[0], 1'b1);
`else
    chk("T4.ovf0", ovf_a[0], 1'b0);
`endif

    // readout sweep while B is frozen in DONE
    data_b = {MK_B, MK_B};
    for (int s = 0; s < 3; s++) begin
      sel_b = 2'(s);
      tick();
      chk($sformatf("T6.rd%0d", s), rd_b, t6e[s]);
    end
    data_b = '0;
    for (int s = 0; s < 4; s++) begin
      sel_a = 3'(s);
      tick();
    end
    chk("T6.rdA_oob", rd_a, 0);

    // marker already waiting on phase 1
    data_a = 24'h00ff00;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (5) tick();
    data_a[7:0] = MK_A;
    tick();
    data_a[7:0] = 8'h00;
    tick();
    chk("T2.cnt1", counts_a[7:4], 1);
    chk("T2.phase", cp_a, 2);
    chk("T2.cnt0", counts_a[3:0], 5);
    data_a = '0;

    // start wins over a same-cycle marker
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    repeat (7) tick();
    start_b = 1'b1;
    data_b[31:0] = MK_B;
    tick();
    chk("T3.counts", counts_b, 0);
    chk("T3.phase", cp_b, 0);
    chk("T3.busy", busy_b, 1'b1);
    start_b = 1'b0;
    data_b = '0;
    tick();
    chk("T3.cnt0", counts_b[31:0], 1);

    // async reset mid-run
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (3) tick();
    #2 resetn = 1'b0;
    #1;
    mreset();
    check_all();
    chk("T5.rst_cnt", counts_a, 0);
    chk("T5.rst_busy", busy_a, 1'b0);
    #1 resetn = 1'b1;
    repeat (3) tick();
    chk("T5.no_resume", counts_a, 0);
    chk("T5.b_resume", counts_b[31:0], 3);

    // randomized traffic
    repeat (300) begin
      start_a = ($urandom_range(0, 19) == 0);
      start_b = ($urandom_range(0, 19) == 0);
      for (int k = 0; k < 3; k++)
        data_a[k*8 +: 8] = ($urandom_range(0, 3) == 0) ?
          MK_A : 8'($urandom_range(0, 254));
      for (int k = 0; k < 2; k++)
        data_b[k*32 +: 32] = ($urandom_range(0, 5) == 0) ?
          MK_B : 32'($urandom_range(0, 1000));
      sel_a = 3'($urandom_range(0, 4));
      sel_b = 2'($urandom_range(0, 3));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
